// File: rtl/pim_arb_pkg.sv
// rtl/pim_arb_pkg.sv - shared limits, read-tag type and burst FSM states for the PIM bank arbiter
package pim_arb_pkg;
    localparam int MAX_REQ    = 8;
    localparam int MAX_RD_LAT = 4;
    localparam int TAG_IDX_W  = $clog2(MAX_REQ);

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;
endpackage

// File: rtl/pim_bank_arbiter_if.sv
// rtl/pim_bank_arbiter_if.sv - requester, memory-port and response bundle of the PIM bank arbiter
interface pim_bank_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 40,
    parameter int OUT_WIDTH  = 40
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_data;
    logic                          mem_we;
    logic [OUT_WIDTH-1:0]          mem_out;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [OUT_WIDTH-1:0]          rsp_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_data, mem_out,
        output req_ready, mem_addr, mem_data, mem_we, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_data, mem_out,
        input  req_ready, mem_addr, mem_data, mem_we, rsp_valid, rsp_data
    );
endinterface

// File: rtl/pim_rr_picker.sv
// rtl/pim_rr_picker.sv - combinational rotate-priority picker, search starts one above ptr and wraps
module pim_rr_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);
    logic [IW-1:0] pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 1; k <= N; k++) begin
            pos = IW'((int'(ptr) + k) % N);
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end
endmodule

// File: rtl/pim_bank_arbiter.sv
// rtl/pim_bank_arbiter.sv - round-robin arbiter sharing one PIM BRAM port with tagged read returns
// Optional burst priority enabled by defining PIM_ARB_BURST_EN.
module pim_bank_arbiter
    import pim_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 40,
    parameter int OUT_WIDTH  = 40,
    parameter int RD_LAT     = 1,
    parameter int BURST_LEN  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pim_bank_arbiter_if.slave   bus,
    output logic                busy
);
    localparam int IW  = $clog2(NUM_REQ);
    localparam int LAT = (RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : RD_LAT;

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      pick_ptr;
    logic [IW-1:0]      idx;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic [NUM_REQ-1:0] rsp_onehot;
    logic               tag_busy;
    tag_t               tags [LAT+1];

    pim_rr_picker #(.N(NUM_REQ)) u_picker (
        .req   (bus.req_valid),
        .ptr   (pick_ptr),
        .grant (grant),
        .idx   (idx),
        .found (found)
    );

    assign bus.req_ready = grant;

`ifdef PIM_ARB_BURST_EN
    localparam int CW = $clog2(BURST_LEN + 1);

    arb_state_e    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [IW-1:0] owner, owner_d;
    logic          hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            owner <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            owner <= owner_d;
        end
    end

    // Holding the owner is done by starting the search right at the owner.
    always_comb begin
        hold     = (state == ST_HOLD) && (cnt < CW'(BURST_LEN)) && bus.req_valid[owner];
        pick_ptr = ptr;
        if (hold) pick_ptr = (owner == '0) ? IW'(NUM_REQ - 1) : owner - 1'b1;
    end

    always_comb begin
        state_d = found ? ST_HOLD : ST_IDLE;
        cnt_d   = cnt;
        owner_d = owner;
        if (found) begin
            if (hold) begin
                cnt_d = cnt + 1'b1;
            end else begin
                cnt_d   = CW'(1);
                owner_d = idx;
            end
        end
    end
`else
    assign pick_ptr = ptr;
`endif

    always_comb begin
        rsp_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rsp_onehot[i] = tags[LAT].valid && (tags[LAT].idx == TAG_IDX_W'(i));
    end

    always_comb begin
        tag_busy = 1'b0;
        for (int k = 0; k <= LAT; k++) tag_busy = tag_busy | tags[k].valid;
    end

    assign busy = bus.mem_we | tag_busy | (|bus.rsp_valid);

    // tags[LAT] lines up with the cycle in which mem_out carries that read's data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= IW'(NUM_REQ - 1);
            bus.mem_addr  <= '0;
            bus.mem_data  <= '0;
            bus.mem_we    <= 1'b0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            for (int k = 0; k <= LAT; k++) tags[k] <= '0;
        end else begin
            bus.mem_we <= found & bus.req_we[idx];
            tags[0]    <= '{valid: found & ~bus.req_we[idx], idx: TAG_IDX_W'(idx)};
            for (int k = 1; k <= LAT; k++) tags[k] <= tags[k-1];
            if (found) begin
                ptr          <= idx;
                bus.mem_addr <= bus.req_addr[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
                bus.mem_data <= bus.req_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
            end
            bus.rsp_valid <= rsp_onehot;
            if (tags[LAT].valid) bus.rsp_data <= bus.mem_out;
        end
    end
endmodule

// File: doc/pim_bank_arbiter.md
Name: pim_bank_arbiter

Overview:
Round-robin arbiter that shares one PIM BRAM array (split-bank memory, single access per cycle, fixed read latency) between NUM_REQ independent requesters. Accepts per-requester valid/ready transactions, issues at most one registered access per cycle to the memory port, and tracks in-flight reads with a tag pipeline so each read result returns to the requester that issued it. Sits between compute/DMA clients and the top-level memory wrapper.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 9, memory address width
DATA_WIDTH, 40, write data width
OUT_WIDTH, 40, read data width
RD_LAT, 1, memory read latency in cycles from mem_* issue to mem_out valid (1..4)
BURST_LEN, 4, max consecutive grants to one requester (optional feature only)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant/accept, combinational from state and req_valid
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  in  NUM_REQ*DATA_WIDTH  packed write data
mem_addr  out  ADDR_WIDTH  registered memory address
mem_data  out  DATA_WIDTH  registered memory write data
mem_we  out  1  registered write enable, pulse per accepted write
mem_out  in  OUT_WIDTH  memory read data, valid RD_LAT cycles after issue
rsp_valid  out  NUM_REQ  one-hot read-response strobe, registered
rsp_data  out  OUT_WIDTH  registered read data, qualified by rsp_valid
busy  out  1  high while any access is issued or any read is in flight

Behaviour:
- Reset: req_ready=0 pending state; mem_addr=0, mem_data=0, mem_we=0, rsp_valid=0, rsp_data=0, busy=0; rr pointer = NUM_REQ-1 (requester 0 highest priority first); tag pipeline cleared.
- Arbitration: each cycle, search from (ptr+1) mod NUM_REQ upward, wrapping; first i with req_valid[i] gets req_ready[i]=1. At most one ready bit set. No valid -> req_ready=0, ptr holds.
- Handshake at cycle T (valid & ready): ptr <= i; mem_addr/mem_data/mem_we registered from requester i at T+1. Cycle with no handshake: mem_we=0, mem_addr/mem_data hold.
- Reads: tag {valid, index} enters RD_LAT+1 deep shift register at T. At T+1+RD_LAT mem_out is sampled; at T+2+RD_LAT rsp_data=mem_out, rsp_valid[i]=1 for one cycle. Default RD_LAT=1: response at T+3.
- Writes: no response; mem_we high exactly one cycle (T+1).
- Throughput: one accepted access per cycle, back-to-back reads pipeline fully; responses return in issue order.
- Requester must hold valid/we/addr/data stable until ready; deasserting valid before ready is allowed (request withdrawn, no side effect).
- All NUM_REQ valid continuously: grants rotate 0,1,2,...,NUM_REQ-1,0 — each requester exactly once per NUM_REQ cycles.
- ptr wrap: ptr=NUM_REQ-1 -> search begins at 0.
- busy = mem_we | any tag valid | any rsp_valid.
- Reset mid-operation: in-flight reads discarded, no rsp_valid after reset release; memory contents untouched.

Optional Feature:
PIM_ARB_BURST_EN — defined: FSM IDLE/HOLD. After a grant to i, enter HOLD; while req_valid[i] stays high and burst counter < BURST_LEN, i keeps priority; counter reaches BURST_LEN or valid drops -> ptr <= i, normal round-robin, back to IDLE. Not defined: pure single-grant round-robin, no counter, no FSM logic.

Decomposition:
- Package pim_arb_pkg: tag struct {valid, idx[$clog2(NUM_REQ)-1:0]}, FSM state enum, max RD_LAT constant.
- One sub-module pim_rr_picker: combinational rotate-priority one-hot picker (req vector + ptr -> grant one-hot + index).

Test Plan:
- Single read: req_valid=0001, addr=0x05, RD_LAT=1 -> req_ready=0001 at T, mem_addr=0x05 mem_we=0 at T+1, rsp_valid=0001 with mem_out value at T+3.
- Single write: requester 2 we=1 addr=0x1FF data=0xAB_CDEF_0123 -> mem_we=1 for one cycle with those values at T+1, no rsp_valid ever.
- Full contention: req_valid=1111 held 8 cycles, all reads -> grant sequence 0,1,2,3,0,1,2,3; rsp_valid order identical, 3 cycles delayed.
- Wrap/skip: ptr=3, req_valid=0100 -> grant 2 immediately; next cycle req_valid=0101 -> grant 0.
- Reset mid-flight: issue reads from 1 and 3 back-to-back, assert rst_n=0 at T+1 -> all outputs zero, no rsp_valid after release, busy=0.
- PIM_ARB_BURST_EN, BURST_LEN=4, req_valid=0011 held -> grants 0,0,0,0,1,1,1,1,0...
